// File: rtl/global_buffer_pingpong_if.sv
// Producer/consumer bus for the ping-pong global buffer.
// The master side fills and drains the banks; the slave side is the buffer itself.
interface global_buffer_pingpong_if #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 11
);
    localparam int unsigned STRB_BITS = DATA_BITS / 8;

    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_index;
    logic [DATA_BITS-1:0] wr_data;
    logic [STRB_BITS-1:0] wr_strb;
    logic                 wr_done;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_index;
    logic                 rd_done;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 fill_ready;
    logic                 drain_ready;
    logic                 fill_sel;
    logic [ADDR_BITS:0]   wr_count;
    logic                 err_wr;
    logic                 err_rd;

    modport master (
        output wr_en, wr_index, wr_data, wr_strb, wr_done,
        output rd_en, rd_index, rd_done,
        input  rd_data, rd_valid, fill_ready, drain_ready, fill_sel, wr_count, err_wr, err_rd
    );

    modport slave (
        input  wr_en, wr_index, wr_data, wr_strb, wr_done,
        input  rd_en, rd_index, rd_done,
        output rd_data, rd_valid, fill_ready, drain_ready, fill_sel, wr_count, err_wr, err_rd
    );
endinterface

// File: rtl/global_buffer_pingpong.sv
// Double-buffered global buffer: the producer fills one bank while the consumer drains the
// other; banks swap on accepted done handshakes.
module global_buffer_pingpong #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 11,
    parameter int unsigned DEPTH     = 2048
) (
    input logic                    clk,
    input logic                    rst,
    global_buffer_pingpong_if.slave bus_io
);
    localparam int unsigned STRB_BITS = DATA_BITS / 8;
    localparam int unsigned CNT_BITS  = ADDR_BITS + 1;
    localparam int unsigned IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_BITS-1:0] DepthLim = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0] CntMax   = '1;

    typedef enum logic [1:0] {StEmpty, StOne, StBoth} state_e;

    state_e               state_q, state_d;
    logic                 fill_sel_q, fill_sel_d;
    logic [CNT_BITS-1:0]  wr_count_q, wr_count_d;
    logic                 err_wr_q, err_wr_d;
    logic                 err_rd_q, err_rd_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic [DATA_BITS-1:0] mem_q [2][DEPTH];

    logic                fill_ready, drain_ready;
    logic                wr_in_range, rd_in_range;
    logic                wr_accept, rd_accept;
    logic                wr_done_acc, rd_done_acc;
    logic [IDX_BITS-1:0] wr_idx, rd_idx;

    // Indices are only used when range-checked, so truncation is safe.
    assign wr_idx = wr_in_range ? bus_io.wr_index[IDX_BITS-1:0] : '0;
    assign rd_idx = rd_in_range ? bus_io.rd_index[IDX_BITS-1:0] : '0;

    always_comb begin
        fill_ready  = (state_q != StBoth);
        drain_ready = (state_q != StEmpty);
        wr_in_range = ({1'b0, bus_io.wr_index} < DepthLim);
        rd_in_range = ({1'b0, bus_io.rd_index} < DepthLim);
        wr_accept   = bus_io.wr_en & fill_ready & wr_in_range;
        rd_accept   = bus_io.rd_en & drain_ready & rd_in_range;
        wr_done_acc = bus_io.wr_done & fill_ready;
        rd_done_acc = bus_io.rd_done & drain_ready;
    end

    always_comb begin
        state_d    = state_q;
        fill_sel_d = fill_sel_q;
        unique case (state_q)
            StEmpty: begin
                if (wr_done_acc) begin
                    state_d    = StOne;
                    fill_sel_d = ~fill_sel_q;
                end
            end
            StOne: begin
                if (wr_done_acc && rd_done_acc) begin
                    fill_sel_d = ~fill_sel_q;
                end else if (wr_done_acc) begin
                    state_d = StBoth;
                end else if (rd_done_acc) begin
                    state_d = StEmpty;
                end
            end
            StBoth: begin
                if (rd_done_acc) begin
                    state_d    = StOne;
                    fill_sel_d = ~fill_sel_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_done_acc) begin
            wr_count_d = '0;
        end else if (wr_accept && wr_count_q != CntMax) begin
            wr_count_d = wr_count_q + 1'b1;
        end

        err_wr_d = err_wr_q | (bus_io.wr_en & ~fill_ready) | (bus_io.wr_en & ~wr_in_range)
                 | (bus_io.wr_done & ~fill_ready);
        err_rd_d = err_rd_q | (bus_io.rd_en & ~drain_ready) | (bus_io.rd_en & ~rd_in_range)
                 | (bus_io.rd_done & ~drain_ready);

        // Read uses the pre-swap drain bank, even when rd_done lands in the same cycle.
        rd_valid_d = rd_accept;
        rd_data_d  = rd_accept ? mem_q[~fill_sel_q][rd_idx] : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            fill_sel_q <= 1'b0;
            wr_count_q <= '0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_sel_q <= fill_sel_d;
            wr_count_q <= wr_count_d;
            err_wr_q   <= err_wr_d;
            err_rd_q   <= err_rd_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < STRB_BITS; i++) begin
                if (bus_io.wr_strb[i]) begin
                    mem_q[fill_sel_q][wr_idx][8*i +: 8] <= bus_io.wr_data[8*i +: 8];
                end
            end
        end
    end

    assign bus_io.rd_data     = rd_data_q;
    assign bus_io.rd_valid    = rd_valid_q;
    assign bus_io.fill_ready  = fill_ready;
    assign bus_io.drain_ready = drain_ready;
    assign bus_io.fill_sel    = fill_sel_q;
    assign bus_io.wr_count    = wr_count_q;
    assign bus_io.err_wr      = err_wr_q;
    assign bus_io.err_rd      = err_rd_q;
endmodule

// File: tb/tb_global_buffer_pingpong.sv
// Directed bench for the ping-pong buffer: handshakes, strobes, errors and async reset.
// DEPTH is below 2**ADDR_BITS so out-of-range indices can be driven.
module tb_global_buffer_pingpong;
    localparam int unsigned DataBits = 32;
    localparam int unsigned AddrBits = 11;
    localparam int unsigned Depth    = 1024;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    global_buffer_pingpong_if #(.DATA_BITS(DataBits), .ADDR_BITS(AddrBits)) bus ();

    global_buffer_pingpong #(
        .DATA_BITS(DataBits),
        .ADDR_BITS(AddrBits),
        .DEPTH    (Depth)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.wr_index = '0;
        bus.wr_data  = '0;
        bus.wr_strb  = '0;
        bus.wr_done  = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_index = '0;
        bus.rd_done  = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [31:0] data, input logic [3:0] strb);
        bus.wr_en    = 1'b1;
        bus.wr_index = AddrBits'(idx);
        bus.wr_data  = data;
        bus.wr_strb  = strb;
        step();
        idle();
    endtask

    task automatic rd(input int idx);
        bus.rd_en    = 1'b1;
        bus.rd_index = AddrBits'(idx);
        step();
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst = 1'b1;
        #3;
        chk("rst_fill_sel", bus.fill_sel, 0);
        chk("rst_drain_ready", bus.drain_ready, 0);
        chk("rst_fill_ready", bus.fill_ready, 1);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_wr_count", bus.wr_count, 0);
        chk("rst_err_wr", bus.err_wr, 0);
        chk("rst_err_rd", bus.err_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Read and rd_done while EMPTY
        rd(2);
        chk("empty_rd_valid", bus.rd_valid, 0);
        chk("empty_err_rd", bus.err_rd, 1);
        chk("empty_rd_data", bus.rd_data, 0);
        bus.rd_done = 1'b1;
        step();
        idle();
        chk("empty_rd_done_ign", bus.drain_ready, 0);

        // Three writes then async reset between edges
        for (int i = 0; i < 3; i++) wr(i, 32'hCAFE0000 + 32'(i), 4'hF);
        chk("fill3_wr_count", bus.wr_count, 3);
        chk("fill3_err_wr", bus.err_wr, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_count", bus.wr_count, 0);
        chk("arst_err_rd", bus.err_rd, 0);
        chk("arst_fill_sel", bus.fill_sel, 0);
        chk("arst_drain_ready", bus.drain_ready, 0);
        chk("arst_fill_ready", bus.fill_ready, 1);
        #2 rst = 1'b0;
        step();

        // Basic fill, handoff, read
        for (int i = 0; i < 4; i++) wr(i, 32'h11111111 * 32'(i + 1), 4'hF);
        chk("fill4_wr_count", bus.wr_count, 4);
        bus.wr_done = 1'b1;
        step();
        idle();
        chk("hand_drain_ready", bus.drain_ready, 1);
        chk("hand_fill_ready", bus.fill_ready, 1);
        chk("hand_fill_sel", bus.fill_sel, 1);
        chk("hand_wr_count", bus.wr_count, 0);
        rd(2);
        chk("rd2_valid", bus.rd_valid, 1);
        chk("rd2_data", bus.rd_data, 32'h33333333);
        step();
        chk("rd2_valid_drop", bus.rd_valid, 0);
        chk("rd2_data_hold", bus.rd_data, 32'h33333333);

        // Byte strobes into bank1, then simultaneous read + rd_done + wr_done
        wr(5, 32'hAABBCCDD, 4'hF);
        wr(5, 32'h00000011, 4'h1);
        wr(1, 32'h55555555, 4'hF);
        bus.rd_en    = 1'b1;
        bus.rd_index = AddrBits'(1);
        bus.rd_done  = 1'b1;
        bus.wr_done  = 1'b1;
        step();
        idle();
        chk("sim_rd_valid", bus.rd_valid, 1);
        chk("sim_rd_data", bus.rd_data, 32'h22222222);
        chk("sim_fill_sel", bus.fill_sel, 0);
        chk("sim_drain_ready", bus.drain_ready, 1);
        chk("sim_fill_ready", bus.fill_ready, 1);
        chk("sim_wr_count", bus.wr_count, 0);
        rd(5);
        chk("strb_rd_data", bus.rd_data, 32'hAABBCC11);
        rd(1);
        chk("bank1_idx1", bus.rd_data, 32'h55555555);

        // Out-of-range write and read
        chk("pre_oob_err_wr", bus.err_wr, 0);
        wr(Depth, 32'h12345678, 4'hF);
        chk("oob_wr_err", bus.err_wr, 1);
        chk("oob_wr_count", bus.wr_count, 0);
        chk("pre_oob_err_rd", bus.err_rd, 0);
        rd(Depth);
        chk("oob_rd_valid", bus.rd_valid, 0);
        chk("oob_rd_err", bus.err_rd, 1);
        chk("oob_rd_hold", bus.rd_data, 32'h55555555);

        // Backpressure: both banks full
        wr(7, 32'h77777777, 4'hF);
        wr(8, 32'hFFFFFFFF, 4'h0);
        chk("strb0_counted", bus.wr_count, 2);
        bus.wr_done = 1'b1;
        step();
        idle();
        chk("both_fill_ready", bus.fill_ready, 0);
        chk("both_drain_ready", bus.drain_ready, 1);
        chk("both_fill_sel", bus.fill_sel, 0);
        chk("both_wr_count", bus.wr_count, 0);
        wr(7, 32'hDEADBEEF, 4'hF);
        chk("blocked_wr_count", bus.wr_count, 0);
        bus.rd_done = 1'b1;
        step();
        idle();
        chk("release_fill_ready", bus.fill_ready, 1);
        chk("release_fill_sel", bus.fill_sel, 1);
        rd(7);
        chk("blocked_mem_kept", bus.rd_data, 32'h77777777);
        rd(0);
        chk("bank0_idx0", bus.rd_data, 32'h11111111);

        // Async reset with a read in flight
        rd(3);
        chk("pre_rst_valid", bus.rd_valid, 1);
        chk("pre_rst_data", bus.rd_data, 32'h44444444);
        #2 rst = 1'b1;
        #1;
        chk("arst2_rd_valid", bus.rd_valid, 0);
        chk("arst2_rd_data", bus.rd_data, 0);
        chk("arst2_fill_sel", bus.fill_sel, 0);
        chk("arst2_drain_ready", bus.drain_ready, 0);
        chk("arst2_err_wr", bus.err_wr, 0);
        chk("arst2_err_rd", bus.err_rd, 0);
        #2 rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
